// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus among N_REQ requesters.
// One transaction at a time: IDLE -> ISSUE -> (read: WAIT) -> DONE -> IDLE.
module mem_bus_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int N_REQ   = 3,
  parameter int MEM_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_rd,
  output logic                      mem_wr,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             we_q;
  logic [3:0]       cnt;

  // Scan downward and overwrite so the lowest offset from rr_ptr wins.
  always_comb begin
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_idx = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (req[j]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_q ? DONE : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      idx       <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (win_vld) begin
          idx       <= win_idx;
          we_q      <= req_we[win_idx];
          mem_addr  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          mem_wdata <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
        end
        ISSUE: cnt <= 4'(MEM_LAT);
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) rdata <= mem_rdata;
        end
        DONE: rr_ptr <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so a reset edge clears them at once.
  always_comb begin
    gnt    = '0;
    ack    = '0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    busy   = (state != IDLE);
    if (state != IDLE) gnt[idx] = 1'b1;
    if (state == DONE) ack[idx] = 1'b1;
    if (state == ISSUE) begin
      mem_rd = ~we_q;
      mem_wr = we_q;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a fixed-latency memory model.
module tb_mem_bus_arbiter;
  localparam int DW = 16, AW = 16, NR = 3, LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req, req_we, gnt, ack;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          busy, mem_rd, mem_wr;

  int tests = 0;
  int fails = 0;

  mem_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_REQ(NR), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: read data is valid only in cycle ISSUE+LAT, garbage otherwise.
  int            lat_cnt = 0;
  logic [AW-1:0] rd_addr = '0;

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  always @(posedge clk) begin
    if (mem_rd) begin
      lat_cnt <= 1;
      rd_addr <= mem_addr;
    end else if (lat_cnt == LAT) lat_cnt <= 0;
    else if (lat_cnt != 0)       lat_cnt <= lat_cnt + 1;
  end
  assign mem_rdata = (lat_cnt == LAT) ? mem_model(rd_addr) : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 3'b111;
    req_we    = 3'b000;
    req_addr  = '0;
    req_wdata = '0;

    // 1. reset with all requests high
    tick(); tick(); tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_rd", 32'(mem_rd), 32'h0);
    check("rst_wr", 32'(mem_wr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    rst_n = 1'b1;
    req   = 3'b000;
    tick();
    check("idle_busy", 32'(busy), 32'h0);

    // 2. read by requester 1
    req = 3'b010; req_addr[1*AW +: AW] = 16'h0040;
    tick();
    check("rd_strobe", 32'(mem_rd), 32'h1);
    check("rd_wr_low", 32'(mem_wr), 32'h0);
    check("rd_addr", 32'(mem_addr), 32'h0040);
    check("rd_gnt", 32'(gnt), 32'h2);
    tick();
    check("rd_strobe_1cyc", 32'(mem_rd), 32'h0);
    check("rd_noack_t2", 32'(ack), 32'h0);
    tick();
    check("rd_noack_t3", 32'(ack), 32'h0);
    check("rd_busy_t3", 32'(busy), 32'h1);
    tick();
    check("rd_ack", 32'(ack), 32'h2);
    check("rd_rdata", 32'(rdata), 32'hBEEF);
    req = 3'b000;
    tick();
    check("rd_ack_pulse", 32'(ack), 32'h0);
    check("rd_idle", 32'(busy), 32'h0);

    // 3. write by requester 0
    req = 3'b001; req_we = 3'b001;
    req_addr[0 +: AW] = 16'h0010; req_wdata[0 +: DW] = 16'h1234;
    tick();
    check("wr_strobe", 32'(mem_wr), 32'h1);
    check("wr_rd_low", 32'(mem_rd), 32'h0);
    check("wr_addr", 32'(mem_addr), 32'h0010);
    check("wr_data", 32'(mem_wdata), 32'h1234);
    check("wr_gnt", 32'(gnt), 32'h1);
    tick();
    check("wr_ack", 32'(ack), 32'h1);
    check("wr_strobe_1cyc", 32'(mem_wr), 32'h0);
    check("wr_rdata_kept", 32'(rdata), 32'hBEEF);
    req = 3'b000; req_we = 3'b000;
    tick();
    check("wr_idle", 32'(busy), 32'h0);

    // reset so the round-robin pointer starts at requester 0
    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // 4. all three reading continuously
    req_addr = {16'h0300, 16'h0200, 16'h0100};
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      logic [NR-1:0] exp_oh;
      logic [AW-1:0] exp_a;
      exp_oh = NR'(1 << (i % NR));
      exp_a  = AW'(16'h0100 * ((i % NR) + 1));
      tick();
      check("rr_gnt", 32'(gnt), 32'(exp_oh));
      check("rr_rd", 32'(mem_rd), 32'h1);
      check("rr_addr", 32'(mem_addr), 32'(exp_a));
      tick(); tick();
      check("rr_noack", 32'(ack), 32'h0);
      tick();
      check("rr_ack", 32'(ack), 32'(exp_oh));
      check("rr_rdata", 32'(rdata), 32'(exp_a ^ 16'hA5A5));
      if (i == 3) req = 3'b000;
      tick();
      check("rr_gap_idle", 32'(busy), 32'h0);
      check("rr_gap_noack", 32'(ack), 32'h0);
    end

    // 5. reset during WAIT aborts the read
    req = 3'b010; req_addr[1*AW +: AW] = 16'h0040;
    tick();
    check("ab_gnt", 32'(gnt), 32'h2);
    tick();
    check("ab_wait", 32'(busy), 32'h1);
    rst_n = 1'b0;
    tick();
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_gnt0", 32'(gnt), 32'h0);
    check("ab_ack0", 32'(ack), 32'h0);
    rst_n = 1'b1; req = 3'b000;
    tick();
    check("ab_noack1", 32'(ack), 32'h0);
    tick();
    check("ab_noack2", 32'(ack), 32'h0);
    check("ab_idle", 32'(busy), 32'h0);
    req = 3'b111;
    tick();
    check("ab_next_winner", 32'(gnt), 32'h1);
    tick(); tick();
    tick();
    check("ab_next_ack", 32'(ack), 32'h1);
    req = 3'b000;
    tick();

    // 6. requester 2 drops req while waiting
    req = 3'b100;
    tick();
    check("drop_gnt", 32'(gnt), 32'h4);
    req = 3'b000;
    tick();
    check("drop_busy", 32'(busy), 32'h1);
    tick();
    tick();
    check("drop_ack", 32'(ack), 32'h4);
    check("drop_rdata", 32'(rdata), 32'h0300 ^ 32'hA5A5);
    tick();
    check("drop_idle", 32'(busy), 32'h0);
    tick();
    check("drop_no_reissue_rd", 32'(mem_rd), 32'h0);
    check("drop_no_reissue_gnt", 32'(gnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
